// File: rtl/interrupt_entry_sequencer.sv
// Interrupt entry sequencer: on an unmasked interrupt, stall fetch, let the
// pipeline drain, inject return-PC and flags stack pushes into ID/EX, then
// redirect the PC to the interrupt vector. Moore machine; every output is
// decoded from registered state.
module interrupt_entry_sequencer #(
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        Int_Mask,
    input  logic [31:0] Fetch_PC,
    input  logic        Taken_Jump,
    input  logic [31:0] Jump_Target,
    input  logic [2:0]  Flags,
    output logic        Stall_Fetch,
    output logic        Inject_Valid,
    output logic        Inject_SP,
    output logic        Inject_SPOP,
    output logic        Inject_MW,
    output logic        Inject_Stack_PC,
    output logic        Inject_Stack_Flags,
    output logic [31:0] Inject_Data,
    output logic        PC_Load,
    output logic [31:0] PC_Load_Value,
    output logic        Int_Ack,
    output logic        Busy
);

    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_bad_drain
        $error("DRAIN_CYCLES must be in 1..7");
    end

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH_PC,
        PUSH_FLAGS,
        VECTOR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        int_d;
    logic        int_pending;
    logic        redirected;
    logic [2:0]  cnt;
    logic [31:0] return_pc;
    logic [2:0]  flags_snap;
    logic        int_edge;
    logic        start;

    assign int_edge = INT & ~int_d;
    assign start    = (state == IDLE) & (int_pending | int_edge) & ~Int_Mask;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Request tracking, drain counter, return PC and flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_d       <= 1'b0;
            int_pending <= 1'b0;
            redirected  <= 1'b0;
            cnt         <= 3'd0;
            return_pc   <= 32'd0;
            flags_snap  <= 3'd0;
        end else begin
            int_d <= INT;
            // Entering consumes one request; a fresh edge arriving while a
            // request is already pending survives as the next request.
            if (start) int_pending <= int_pending & int_edge;
            else       int_pending <= int_pending | int_edge;

            if (start) begin
                return_pc  <= Fetch_PC;
                redirected <= 1'b0;
                cnt        <= DRAIN_LAST;
            end

            if (state == DRAIN) begin
                if (cnt != 3'd0) cnt <= cnt - 3'd1;
                // A jump resolving while draining means the fetched PC was
                // on the wrong path; the latest resolved target is the real
                // resume point.
                if (Taken_Jump) begin
                    return_pc  <= Jump_Target;
                    redirected <= 1'b1;
                end
                if (cnt == 3'd0) flags_snap <= Flags;
            end
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_next         = state;
        Stall_Fetch        = 1'b0;
        Inject_Valid       = 1'b0;
        Inject_SP          = 1'b0;
        Inject_SPOP        = 1'b0;
        Inject_MW          = 1'b0;
        Inject_Stack_PC    = 1'b0;
        Inject_Stack_Flags = 1'b0;
        Inject_Data        = 32'd0;
        PC_Load            = 1'b0;
        PC_Load_Value      = 32'd0;
        Int_Ack            = 1'b0;
        Busy               = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = DRAIN;
            end
            DRAIN: begin
                Stall_Fetch = 1'b1;
                if (cnt == 3'd0) state_next = PUSH_PC;
            end
            PUSH_PC: begin
                Stall_Fetch     = 1'b1;
                Inject_Valid    = 1'b1;
                Inject_SP       = 1'b1;
                Inject_MW       = 1'b1;
                Inject_Stack_PC = 1'b1;
                Inject_Data     = return_pc;
                state_next      = PUSH_FLAGS;
            end
            PUSH_FLAGS: begin
                Stall_Fetch        = 1'b1;
                Inject_Valid       = 1'b1;
                Inject_SP          = 1'b1;
                Inject_MW          = 1'b1;
                Inject_Stack_Flags = 1'b1;
                Inject_Data        = {29'd0, flags_snap};
                state_next         = VECTOR;
            end
            VECTOR: begin
                Stall_Fetch   = 1'b1;
                PC_Load       = 1'b1;
                PC_Load_Value = VECTOR_ADDR;
                Int_Ack       = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A jump seen while draining must leave the return PC marked redirected.
    a_redirect: assert property (@(posedge clk) disable iff (rst)
        (state == DRAIN && Taken_Jump) |=> redirected);

endmodule

// File: tb/tb_interrupt_entry_sequencer.sv
// Randomised scoreboard bench for interrupt_entry_sequencer. A reference
// model tracks requests and a cycle position within the entry sequence,
// queuing the expected injection/vector outputs; a monitor pops and compares.
module tb_interrupt_entry_sequencer;

    localparam int          D  = 4;
    localparam logic [31:0] VA = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst, INT, Int_Mask, Taken_Jump;
    logic [31:0] Fetch_PC, Jump_Target;
    logic [2:0]  Flags;
    logic        Stall_Fetch, Inject_Valid, Inject_SP, Inject_SPOP, Inject_MW;
    logic        Inject_Stack_PC, Inject_Stack_Flags, PC_Load, Int_Ack, Busy;
    logic [31:0] Inject_Data, PC_Load_Value;

    int checks = 0;
    int errors = 0;

    interrupt_entry_sequencer #(.DRAIN_CYCLES(D), .VECTOR_ADDR(VA)) dut (
        .clk(clk), .rst(rst), .INT(INT), .Int_Mask(Int_Mask),
        .Fetch_PC(Fetch_PC), .Taken_Jump(Taken_Jump), .Jump_Target(Jump_Target),
        .Flags(Flags), .Stall_Fetch(Stall_Fetch), .Inject_Valid(Inject_Valid),
        .Inject_SP(Inject_SP), .Inject_SPOP(Inject_SPOP), .Inject_MW(Inject_MW),
        .Inject_Stack_PC(Inject_Stack_PC), .Inject_Stack_Flags(Inject_Stack_Flags),
        .Inject_Data(Inject_Data), .PC_Load(PC_Load), .PC_Load_Value(PC_Load_Value),
        .Int_Ack(Int_Ack), .Busy(Busy)
    );

    always #5 clk = ~clk;

    // {Valid, SP, SPOP, MW, Stack_PC, Stack_Flags, Data, PC_Load, PC value, Ack}
    function automatic logic [71:0] pack(input logic iv, sp, spop, mw, spc, sfl,
                                         input logic [31:0] data, input logic pl,
                                         input logic [31:0] plv, input logic ack);
        return {iv, sp, spop, mw, spc, sfl, data, pl, plv, ack};
    endfunction

    // Reference model state: t = 0 when idle, else position in the sequence
    // (1..D drain, D+1 push PC, D+2 push flags, D+3 vector).
    logic [71:0] exp_q[$];
    int          t        = 0;
    bit          pending  = 0;
    bit          prev_int = 0;
    bit          exp_busy = 0;
    logic [31:0] ret      = '0;
    logic [2:0]  fsnap    = '0;
    int          acks     = 0;

    // Reference model, advanced on every clock edge with that cycle's inputs.
    always @(posedge clk) begin : model
        int req;
        if (rst) begin
            t = 0; pending = 0; prev_int = 0; ret = '0; fsnap = '0;
            exp_q.delete();
        end else begin
            req = int'(pending) + int'(INT && !prev_int);
            prev_int = INT;
            if (t == 0) begin
                if (req > 0 && !Int_Mask) begin
                    req = req - 1;
                    t   = 1;
                    ret = Fetch_PC;
                end
            end else begin
                if (t <= D && Taken_Jump) ret = Jump_Target;
                if (t == D) fsnap = Flags;
                t = (t == D + 3) ? 0 : t + 1;
            end
            pending = (req > 0);
            if (t == D + 1) exp_q.push_back(pack(1, 1, 0, 1, 1, 0, ret, 0, 32'd0, 0));
            if (t == D + 2) exp_q.push_back(pack(1, 1, 0, 1, 0, 1, {29'd0, fsnap}, 0, 32'd0, 0));
            if (t == D + 3) begin
                exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 32'd0, 1, VA, 1));
                acks++;
            end
        end
        exp_busy = (t != 0);
    end

    // Monitor: compare presented outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin : monitor
        logic [71:0] got, exp;
        got = pack(Inject_Valid, Inject_SP, Inject_SPOP, Inject_MW, Inject_Stack_PC,
                   Inject_Stack_Flags, Inject_Data, PC_Load, PC_Load_Value, Int_Ack);
        if (got != '0 || exp_q.size() > 0) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL outputs t=%0t actual %h required %h", $time, got, exp);
            end
        end
        checks++;
        if ({Busy, Stall_Fetch} !== {exp_busy, exp_busy}) begin
            errors++;
            $display("FAIL busy_stall t=%0t actual %b%b required %b%b",
                     $time, Busy, Stall_Fetch, exp_busy, exp_busy);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_int();
        INT = 1'b1; cyc(); INT = 1'b0;
    endtask

    initial begin
        int ack_base;
        rst = 1'b1; INT = 1'b0; Int_Mask = 1'b0; Taken_Jump = 1'b0;
        Fetch_PC = '0; Jump_Target = '0; Flags = '0;
        cyc(3);
        rst = 1'b0;
        cyc(5);

        // Basic entry.
        Fetch_PC = 32'h40; Flags = 3'b101;
        pulse_int(); cyc(12);

        // One jump on the second drain cycle.
        Fetch_PC = 32'h44; Flags = 3'b010;
        pulse_int(); cyc();
        Taken_Jump = 1'b1; Jump_Target = 32'h200; cyc();
        Taken_Jump = 1'b0; cyc(10);

        // Two jumps on consecutive drain cycles; the later one wins.
        pulse_int(); cyc();
        Taken_Jump = 1'b1; Jump_Target = 32'h100; cyc();
        Jump_Target = 32'h300; cyc();
        Taken_Jump = 1'b0; cyc(10);

        // Masked request stays pending until unmasked.
        Int_Mask = 1'b1; pulse_int(); cyc(20);
        Int_Mask = 1'b0; cyc(12);

        // Edge during PUSH_FLAGS yields a second, back-to-back entry.
        ack_base = acks;
        pulse_int(); cyc(5);
        pulse_int(); cyc(20);
        checks++;
        if (acks - ack_base != 2) begin
            errors++;
            $display("FAIL nested_acks actual %0d required 2", acks - ack_base);
        end

        // Level held high is one request.
        ack_base = acks;
        INT = 1'b1; cyc(50); INT = 1'b0; cyc(5);
        checks++;
        if (acks - ack_base != 1) begin
            errors++;
            $display("FAIL level_acks actual %0d required 1", acks - ack_base);
        end

        // Reset in the second drain cycle aborts the sequence.
        pulse_int(); cyc();
        rst = 1'b1; cyc();
        rst = 1'b0; cyc(15);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) INT = ~INT;
            if ($urandom_range(19) == 0) Int_Mask = ~Int_Mask;
            Taken_Jump  = ($urandom_range(2) == 0);
            Jump_Target = $urandom;
            Fetch_PC    = $urandom;
            Flags       = 3'($urandom);
            rst         = ($urandom_range(199) == 0);
            cyc();
        end
        rst = 1'b0; INT = 1'b0; Int_Mask = 1'b0; Taken_Jump = 1'b0;
        cyc(20);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue actual %0d required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
